// File: rtl/core_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_pkg
// Brief    : Shared types for the core memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package core_mem_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   kill;
    } outstanding_entry_t;

    localparam int unsigned MAX_OUTSTANDING_DEFAULT = 2;

endpackage
`default_nettype wire

// File: rtl/core_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arbiter_if
// Brief    : Fetch, load/store and memory-side signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface core_mem_arbiter_if;
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic        inst_grnt_o;
    logic        inst_kill_i;
    logic        inst_rvalid_o;
    logic [31:0] inst_rdata_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_grnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_grnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    // Arbiter side
    modport slave (
        input  inst_req_i, inst_addr_i, inst_kill_i,
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  mem_grnt_i, mem_rvalid_i, mem_rdata_i,
        output inst_grnt_o, inst_rvalid_o, inst_rdata_o,
        output data_grnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );

    // Requester/memory environment side
    modport master (
        output inst_req_i, inst_addr_i, inst_kill_i,
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output mem_grnt_i, mem_rvalid_i, mem_rdata_i,
        input  inst_grnt_o, inst_rvalid_o, inst_rdata_o,
        input  data_grnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/core_mem_owner_fifo.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_owner_fifo
// Brief    : In-order owner/kill record of granted, unanswered transactions.
// Revision : 1.0 - initial release
// ============================================================================
module core_mem_owner_fifo
    import core_mem_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_OUTSTANDING_DEFAULT
) (
    input  wire logic               clk_i,
    input  wire logic               arst_ni,
    input  wire logic               push_i,
    input  wire outstanding_entry_t push_entry_i,
    input  wire logic               pop_i,
    input  wire logic               kill_inst_i,
    output outstanding_entry_t      head_o,
    output logic                    empty_o,
    output logic                    full_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_last  = PTR_W'(DEPTH - 1);

    outstanding_entry_t r_entries [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_last) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == c_depth);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign head_o  = r_entries[r_rd_ptr];

    // A freshly pushed slot takes priority over the kill broadcast so a
    // fetch granted in the kill cycle survives.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk_i or negedge arst_ni) begin
            if (!arst_ni) begin
                r_entries[gi] <= '{owner: OWNER_INST, kill: 1'b0};
            end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                r_entries[gi] <= push_entry_i;
            end else if (kill_inst_i && (r_entries[gi].owner == OWNER_INST)) begin
                r_entries[gi].kill <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arbiter
// Brief    : Shares one memory port between fetch and load/store requesters.
// Revision : 1.0 - initial release
// ============================================================================
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  wire logic         clk_i,
    input  wire logic         arst_ni,
    core_mem_arbiter_if.slave bus
);
    logic               r_lock_vld;
    owner_e             r_lock_owner;
    logic               r_data_last;
    owner_e             w_owner;
    logic               w_both;
    logic               w_lock_req;
    logic               w_owner_req;
    logic               w_mem_req;
    logic               w_grant;
    logic               w_full;
    logic               w_empty;
    logic               w_rsp;
    outstanding_entry_t w_head;
    outstanding_entry_t w_push_entry;

    always_comb begin
        w_both      = bus.inst_req_i && bus.data_req_i;
        w_lock_req  = (r_lock_owner == OWNER_DATA) ? bus.data_req_i : bus.inst_req_i;
        w_owner     = OWNER_DATA;
        if (r_lock_vld && w_lock_req)  w_owner = r_lock_owner;
        else if (w_both)               w_owner = r_data_last ? OWNER_INST : OWNER_DATA;
        else if (bus.inst_req_i)       w_owner = OWNER_INST;
        w_owner_req = (w_owner == OWNER_DATA) ? bus.data_req_i : bus.inst_req_i;
        w_mem_req   = w_owner_req && !w_full;
        w_grant     = w_mem_req && bus.mem_grnt_i;
        w_rsp       = bus.mem_rvalid_i && !w_empty;
    end

    // Every output is forced low while reset is asserted, even the purely
    // combinational request and response paths.
    always_comb begin
        bus.mem_req_o     = arst_ni && w_mem_req;
        bus.mem_addr_o    = '0;
        bus.mem_we_o      = 1'b0;
        bus.mem_be_o      = '0;
        bus.mem_wdata_o   = '0;
        bus.inst_grnt_o   = arst_ni && w_grant && (w_owner == OWNER_INST);
        bus.data_grnt_o   = arst_ni && w_grant && (w_owner == OWNER_DATA);
        bus.inst_rvalid_o = arst_ni && w_rsp && (w_head.owner == OWNER_INST)
                            && !w_head.kill && !bus.inst_kill_i;
        bus.data_rvalid_o = arst_ni && w_rsp && (w_head.owner == OWNER_DATA)
                            && !w_head.kill;
        bus.inst_rdata_o  = arst_ni ? bus.mem_rdata_i : '0;
        bus.data_rdata_o  = arst_ni ? bus.mem_rdata_i : '0;
        if (arst_ni) begin
            if (w_owner == OWNER_DATA) begin
                bus.mem_addr_o  = bus.data_addr_i;
                bus.mem_we_o    = bus.data_we_i;
                bus.mem_be_o    = bus.data_be_i;
                bus.mem_wdata_o = bus.data_wdata_i;
            end else begin
                bus.mem_addr_o  = bus.inst_addr_i;
                bus.mem_be_o    = 4'b1111;
            end
        end
    end

    // Priority flag moves only when a conflict is actually granted.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_lock_vld   <= 1'b0;
            r_lock_owner <= OWNER_INST;
            r_data_last  <= 1'b0;
        end else begin
            r_lock_vld   <= w_mem_req && !bus.mem_grnt_i;
            r_lock_owner <= w_owner;
            if (w_grant && w_both) r_data_last <= (w_owner == OWNER_DATA);
        end
    end

    assign w_push_entry = '{owner: w_owner, kill: 1'b0};

    core_mem_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .push_i       (w_grant),
        .push_entry_i (w_push_entry),
        .pop_i        (bus.mem_rvalid_i),
        .kill_inst_i  (bus.inst_kill_i),
        .head_o       (w_head),
        .empty_o      (w_empty),
        .full_o       (w_full)
    );
endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_mem_arbiter
// Brief    : Directed self-checking bench for core_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;
    logic clk_i   = 1'b0;
    logic arst_ni = 1'b0;
    int   n_run   = 0;
    int   n_fail  = 0;

    always #5 clk_i = ~clk_i;

    core_mem_arbiter_if bus();

    core_mem_arbiter #(
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        bus.inst_req_i   = 1'b0;
        bus.inst_addr_i  = '0;
        bus.inst_kill_i  = 1'b0;
        bus.data_req_i   = 1'b0;
        bus.data_addr_i  = '0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = '0;
        bus.data_wdata_i = '0;
        bus.mem_grnt_i   = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Outputs stay low while reset is held, even with live inputs
        idle();
        bus.inst_req_i   = 1'b1;
        bus.inst_addr_i  = 32'h100;
        bus.mem_grnt_i   = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h1234_5678;
        #2;
        chk("rst_mem_req",     32'(bus.mem_req_o),     0);
        chk("rst_inst_grnt",   32'(bus.inst_grnt_o),   0);
        chk("rst_mem_addr",    bus.mem_addr_o,         0);
        chk("rst_inst_rvalid", 32'(bus.inst_rvalid_o), 0);
        chk("rst_inst_rdata",  bus.inst_rdata_o,       0);
        idle();
        @(negedge clk_i);
        arst_ni = 1'b1;
        cyc();

        // Single fetch, response two cycles after grant
        bus.inst_req_i  = 1'b1;
        bus.inst_addr_i = 32'h100;
        bus.mem_grnt_i  = 1'b1;
        #1;
        chk("t1_inst_grnt", 32'(bus.inst_grnt_o), 1);
        chk("t1_data_grnt", 32'(bus.data_grnt_o), 0);
        chk("t1_mem_addr",  bus.mem_addr_o,       32'h100);
        chk("t1_mem_be",    32'(bus.mem_be_o),    32'hF);
        chk("t1_mem_we",    32'(bus.mem_we_o),    0);
        cyc();
        idle();
        cyc();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hDEAD_BEEF;
        #1;
        chk("t1_inst_rvalid", 32'(bus.inst_rvalid_o), 1);
        chk("t1_inst_rdata",  bus.inst_rdata_o,       32'hDEAD_BEEF);
        chk("t1_data_rvalid", 32'(bus.data_rvalid_o), 0);
        cyc();
        idle();

        // Both requesting every cycle: data, inst, data, inst
        bus.inst_req_i  = 1'b1;
        bus.inst_addr_i = 32'h300;
        bus.data_req_i  = 1'b1;
        bus.data_addr_i = 32'h400;
        bus.data_be_i   = 4'hF;
        bus.mem_grnt_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid_i = (i > 0);
            bus.mem_rdata_i  = 32'h1000 + 32'(i);
            #1;
            chk("t2_data_grnt", 32'(bus.data_grnt_o), 32'((i % 2) == 0));
            chk("t2_inst_grnt", 32'(bus.inst_grnt_o), 32'((i % 2) == 1));
            chk("t2_mem_addr",  bus.mem_addr_o, ((i % 2) == 0) ? 32'h400 : 32'h300);
            if (i > 0) begin
                chk("t2_data_rvalid", 32'(bus.data_rvalid_o), 32'(((i - 1) % 2) == 0));
                chk("t2_inst_rvalid", 32'(bus.inst_rvalid_o), 32'(((i - 1) % 2) == 1));
            end
            cyc();
        end
        idle();
        bus.mem_rvalid_i = 1'b1;
        #1;
        chk("t2_last_inst_rvalid", 32'(bus.inst_rvalid_o), 1);
        chk("t2_last_data_rvalid", 32'(bus.data_rvalid_o), 0);
        cyc();
        idle();

        // Data write held by the memory for three cycles while fetch waits
        bus.data_req_i   = 1'b1;
        bus.data_addr_i  = 32'h200;
        bus.data_we_i    = 1'b1;
        bus.data_be_i    = 4'b0011;
        bus.data_wdata_i = 32'hCAFE_0000;
        bus.inst_req_i   = 1'b1;
        bus.inst_addr_i  = 32'h500;
        for (int i = 0; i < 4; i++) begin
            bus.mem_grnt_i = (i == 3);
            #1;
            chk("t3_mem_req",   32'(bus.mem_req_o),   1);
            chk("t3_mem_addr",  bus.mem_addr_o,       32'h200);
            chk("t3_mem_we",    32'(bus.mem_we_o),    1);
            chk("t3_mem_be",    32'(bus.mem_be_o),    32'h3);
            chk("t3_mem_wdata", bus.mem_wdata_o,      32'hCAFE_0000);
            chk("t3_inst_grnt", 32'(bus.inst_grnt_o), 0);
            chk("t3_data_grnt", 32'(bus.data_grnt_o), 32'(i == 3));
            cyc();
        end
        bus.data_req_i = 1'b0;
        bus.mem_grnt_i = 1'b1;
        #1;
        chk("t3_fetch_grnt",  32'(bus.inst_grnt_o), 1);
        chk("t3_fetch_addr",  bus.mem_addr_o,       32'h500);
        chk("t3_fetch_we",    32'(bus.mem_we_o),    0);
        chk("t3_fetch_be",    32'(bus.mem_be_o),    32'hF);
        chk("t3_fetch_wdata", bus.mem_wdata_o,      0);
        cyc();
        idle();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h11;
        #1;
        chk("t3_wr_data_rvalid", 32'(bus.data_rvalid_o), 1);
        chk("t3_wr_inst_rvalid", 32'(bus.inst_rvalid_o), 0);
        chk("t3_wr_data_rdata",  bus.data_rdata_o,       32'h11);
        cyc();
        #0;
        chk("t3_rd_inst_rvalid", 32'(bus.inst_rvalid_o), 1);
        cyc();
        idle();

        // Full at two outstanding; a pop reopens issue only on the next cycle
        bus.inst_req_i  = 1'b1;
        bus.inst_addr_i = 32'h600;
        bus.mem_grnt_i  = 1'b1;
        #1;
        chk("t4_grnt0", 32'(bus.inst_grnt_o), 1);
        cyc();
        bus.inst_addr_i = 32'h604;
        #1;
        chk("t4_grnt1", 32'(bus.inst_grnt_o), 1);
        cyc();
        bus.mem_rvalid_i = 1'b1;
        #1;
        chk("t4_full_mem_req", 32'(bus.mem_req_o),     0);
        chk("t4_full_grnt",    32'(bus.inst_grnt_o),   0);
        chk("t4_pop_rvalid",   32'(bus.inst_rvalid_o), 1);
        cyc();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_grnt_i   = 1'b0;
        #1;
        chk("t4_reopen_mem_req", 32'(bus.mem_req_o),   1);
        chk("t4_reopen_grnt",    32'(bus.inst_grnt_o), 0);
        cyc();
        bus.inst_req_i   = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        #1;
        chk("t4_drain_rvalid", 32'(bus.inst_rvalid_o), 1);
        cyc();
        idle();

        // Kill: same-cycle response suppressed, marked entry dropped,
        // fetch granted in the kill cycle survives
        bus.inst_req_i  = 1'b1;
        bus.inst_addr_i = 32'h700;
        bus.mem_grnt_i  = 1'b1;
        #1;
        chk("t5_grnt_a", 32'(bus.inst_grnt_o), 1);
        cyc();
        bus.inst_addr_i = 32'h704;
        #1;
        chk("t5_grnt_b", 32'(bus.inst_grnt_o), 1);
        cyc();
        bus.inst_kill_i  = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        #1;
        chk("t5_full_mem_req", 32'(bus.mem_req_o),     0);
        chk("t5_rsp_a_rvalid", 32'(bus.inst_rvalid_o), 0);
        cyc();
        bus.mem_rvalid_i = 1'b0;
        bus.inst_addr_i  = 32'h708;
        #1;
        chk("t5_grnt_c", 32'(bus.inst_grnt_o), 1);
        cyc();
        bus.inst_req_i   = 1'b0;
        bus.inst_kill_i  = 1'b0;
        bus.mem_grnt_i   = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        #1;
        chk("t5_rsp_b_rvalid",  32'(bus.inst_rvalid_o), 0);
        chk("t5_rsp_b_drvalid", 32'(bus.data_rvalid_o), 0);
        cyc();
        #0;
        chk("t5_rsp_c_rvalid", 32'(bus.inst_rvalid_o), 1);
        cyc();
        idle();

        // Reset mid-transaction discards the outstanding entry
        bus.inst_req_i  = 1'b1;
        bus.inst_addr_i = 32'h800;
        bus.mem_grnt_i  = 1'b1;
        #1;
        chk("t6_grnt", 32'(bus.inst_grnt_o), 1);
        cyc();
        #1;
        arst_ni = 1'b0;
        #1;
        chk("t6_rst_mem_req",  32'(bus.mem_req_o),   0);
        chk("t6_rst_inst_grnt", 32'(bus.inst_grnt_o), 0);
        cyc();
        #3;
        arst_ni = 1'b1;
        idle();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hBAD0_BAD0;
        #1;
        chk("t6_stray_inst_rvalid", 32'(bus.inst_rvalid_o), 0);
        chk("t6_stray_data_rvalid", 32'(bus.data_rvalid_o), 0);
        cyc();
        idle();
        bus.inst_req_i = 1'b1;
        bus.mem_grnt_i = 1'b1;
        #1;
        chk("t6_post_grnt0", 32'(bus.inst_grnt_o), 1);
        cyc();
        #0;
        chk("t6_post_grnt1", 32'(bus.inst_grnt_o), 1);
        cyc();
        #0;
        chk("t6_post_full", 32'(bus.mem_req_o), 0);
        cyc();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares the core's single 32-bit memory port between the instruction fetch requester and the load/store (data) requester. Arbitrates requests, holds the winning request stable until the memory grants it, and tracks outstanding transactions in issue order so each response is routed back to its owner. Supports discarding in-flight fetch responses after a redirect. Sits between the fetch/LSU stages and the memory interface.

## Interface
- MAX_OUTSTANDING, 2: max granted-but-unanswered transactions (1..8)
- clk_i  in  1  clock, rising edge
- arst_ni  in  1  reset; asynchronous and active-low
- inst_req_i  in  1  fetch request; held with address until granted
- inst_addr_i  in  32  fetch address
- inst_grnt_o  out  1  fetch request accepted this cycle
- inst_kill_i  in  1  drop all fetch responses still outstanding
- inst_rvalid_o  out  1  fetch response valid
- inst_rdata_o  out  32  fetch response data
- data_req_i  in  1  data request; held with all fields until granted
- data_addr_i  in  32  data address
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_grnt_o  out  1  data request accepted this cycle
- data_rvalid_o  out  1  data response valid (reads and writes)
- data_rdata_o  out  32  data response data
- mem_req_o / mem_addr_o / mem_we_o / mem_be_o / mem_wdata_o  out  1/32/1/4/32  memory request
- mem_grnt_i  in  1  memory accepts request this cycle
- mem_rvalid_i  in  1  memory response valid (one per granted request, in order, ≥1 cycle after grant)
- mem_rdata_i  in  32  memory response data

## Operation
- Owner select:
  - Lock held (previous cycle mem_req_o=1, mem_grnt_i=0, and the locked owner still requesting): owner = locked owner, whatever the other requester does.
  - Otherwise, only one requesting: that one.
  - Both requesting: owner = data, unless the previous granted conflict went to data; then instruction. The priority flag updates only on a granted conflict.
- Request forwarding:
  - mem_req_o = owner's req AND count < MAX_OUTSTANDING.
  - Fields muxed from the owner.
  - Instruction requests drive we=0, be=4'b1111, wdata=0.
- Grant: the owner's grant = mem_grnt_i AND mem_req_o. The other requester's grant = 0.
- Lock: set when mem_req_o=1 and mem_grnt_i=0; records the owner. Cleared on grant, or if the locked requester drops req (protocol violation; arbitration then restarts).
- Outstanding FIFO: depth MAX_OUTSTANDING, entry = {owner, kill}.
  - Push {owner, 0} on grant.
  - Pop head on mem_rvalid_i.
  - Push and pop in the same cycle leave count unchanged.
- Response routing: on mem_rvalid_i, rdata goes to both rdata outputs. The rvalid for the head owner is asserted unless the head entry has kill=1.
- inst_kill_i:
  - Sets kill on every instruction entry present at the start of the cycle.
  - Suppresses inst_rvalid_o for a same-cycle instruction response.
  - An instruction request granted in the same cycle is not killed.
- mem_rvalid_i with an empty FIFO: ignored, no rvalid out, count stays 0.
- Reset: FIFO empty, count 0, lock clear, priority flag = instruction-next-loses (data wins the first conflict). While arst_ni=0, all outputs are 0.

## Timing
- Request and grant paths are combinational: zero added latency, grant in the same cycle as mem_grnt_i.
- Response path is combinational: rvalid/rdata out in the same cycle as mem_rvalid_i.
- Lock, FIFO, count and priority flag update on the rising edge. Kill marks are applied on the same edge.
- Full (count = MAX_OUTSTANDING): mem_req_o=0, both grants 0. Requesters wait. A pop that cycle reopens issue the next cycle, not the same one.
- FIFO pointers wrap modulo MAX_OUTSTANDING. count width is $clog2(MAX_OUTSTANDING+1).
- Reset asserted mid-transaction: all state is discarded immediately. Later responses hit an empty FIFO and are ignored.

## Structure
- Package core_mem_pkg:
  - owner enum {OWNER_INST, OWNER_DATA}
  - packed struct outstanding_entry_t {owner, kill}
  - default MAX_OUTSTANDING constant
- Sub-module core_mem_owner_fifo: entry storage, pointers, count, full/empty, and a broadcast kill that sets kill on all OWNER_INST entries. Arbitration and muxing stay in core_mem_arbiter.

## Test plan
- Only inst_req_i, addr 0x100, mem_grnt_i same cycle, rvalid 2 cycles later with 0xDEADBEEF → inst_grnt_o=1 that cycle; inst_rvalid_o=1 and inst_rdata_o=0xDEADBEEF 2 cycles later; data_rvalid_o=0.
- Both requesting, mem grants every cycle for 4 cycles → grant order data, inst, data, inst; mem_addr_o follows the owner.
- Data write 0x200, mem_grnt_i low for 3 cycles while inst_req_i is high → mem_req_o, mem_addr_o=0x200, we=1 stable all 4 cycles; inst_grnt_o=0 until after the data grant.
- MAX_OUTSTANDING=2, two fetch grants with no response → third request sees mem_req_o=0. One rvalid → mem_req_o=1 on the following cycle.
- Two fetches outstanding, then inst_kill_i pulse, then a new fetch granted in the same cycle, then three responses → only the third produces inst_rvalid_o=1.
- Reset asserted with one entry outstanding, then a stray mem_rvalid_i after release → no rvalid out; count stays 0.
